// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the data-memory stage: memory-op codes,
// stage states, reset constants and store/alignment helper functions.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    NONE  = 4'd0,
    LD_B  = 4'd1,
    LD_H  = 4'd2,
    LD_W  = 4'd3,
    LD_BU = 4'd4,
    LD_HU = 4'd5,
    ST_B  = 4'd6,
    ST_H  = 4'd7,
    ST_W  = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam state_t      RST_STATE  = S_IDLE;
  localparam logic [31:0] RST_RESULT = 32'h0;

  function automatic logic is_load(mem_op_t op);
    return op inside {LD_B, LD_H, LD_W, LD_BU, LD_HU};
  endfunction

  function automatic logic is_store(mem_op_t op);
    return op inside {ST_B, ST_H, ST_W};
  endfunction

  function automatic logic is_aligned(mem_op_t op, logic [1:0] off);
    case (op)
      LD_H, LD_HU, ST_H: return ~off[0];
      LD_W, ST_W:        return off == 2'b00;
      default:           return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(mem_op_t op, logic [1:0] off);
    case (op)
      ST_B:    return 4'b0001 << off;
      ST_H:    return 4'b0011 << off;
      ST_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Narrow stores are replicated so the strobes alone pick the lane.
  function automatic logic [31:0] store_data(mem_op_t op, logic [31:0] d);
    case (op)
      ST_B:    return {4{d[7:0]}};
      ST_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load lane select and sign/zero extension of a returned memory word.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (mem_op_t'(i_op))
      LD_B:    o_data = {{24{w_byte[7]}}, w_byte};
      LD_BU:   o_data = {24'h0, w_byte};
      LD_H:    o_data = {{16{w_half[15]}}, w_half};
      LD_HU:   o_data = {16'h0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Data-memory pipeline stage: issues one bus request per load/store, stalls
// upstream until the ack, and hands the aligned load result to MEM/WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [31:0]       ex_inst,
  input  logic [DATA_W-1:0] ex_alu_res,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic [3:0]        ex_mem_op,
  input  logic [4:0]        ex_rw_addr,
  input  logic              ex_rw_en,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_wstrb,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] mem_pc,
  output logic [31:0]       mem_inst,
  output logic [DATA_W-1:0] mem_rw_data,
  output logic [4:0]        mem_rw_addr,
  output logic              mem_rw_en,
  output logic              mem_ale,
  output logic              mem_stall
);

  state_t            r_state, w_next;
  mem_op_t           w_op, r_req_op, w_la_op;
  logic [1:0]        w_off, r_req_off, w_la_off;
  logic [ADDR_W-1:0] w_word_addr, r_req_addr;
  logic              r_we;
  logic [3:0]        r_wstrb;
  logic [DATA_W-1:0] r_wdata, r_result, w_load_val;
  logic              w_is_mem, w_aligned, w_accept, w_capture;

  assign w_op        = mem_op_t'(ex_mem_op);
  assign w_off       = ex_alu_res[1:0];
  assign w_word_addr = {ex_alu_res[ADDR_W-1:2], 2'b00};
  assign w_is_mem    = is_load(w_op) || is_store(w_op);
  assign w_aligned   = is_aligned(w_op, w_off);
  assign w_accept    = rst && (r_state == S_IDLE) && w_is_mem && w_aligned;

  // While waiting, the captured request decides how the returning word is aligned.
  assign w_la_op   = (r_state == S_WAIT) ? r_req_op  : w_op;
  assign w_la_off  = (r_state == S_WAIT) ? r_req_off : w_off;
  assign w_capture = dmem_ack && (w_accept || (r_state == S_WAIT)) && is_load(w_la_op);

  load_align u_load_align (
    .i_op    (w_la_op),
    .i_off   (w_la_off),
    .i_rdata (dmem_rdata),
    .o_data  (w_load_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RST_STATE;
      r_req_op   <= NONE;
      r_req_off  <= 2'b00;
      r_req_addr <= '0;
      r_we       <= 1'b0;
      r_wstrb    <= 4'b0000;
      r_wdata    <= '0;
      r_result   <= RST_RESULT;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_req_op   <= w_op;
        r_req_off  <= w_off;
        r_req_addr <= w_word_addr;
        r_we       <= is_store(w_op);
        r_wstrb    <= store_strb(w_op, w_off);
        r_wdata    <= store_data(w_op, ex_st_data);
      end
      if (w_capture) r_result <= w_load_val;
    end
  end

  assign mem_pc      = ex_pc;
  assign mem_inst    = ex_inst;
  assign mem_rw_addr = ex_rw_addr;

  always_comb begin
    w_next      = r_state;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = w_word_addr;
    dmem_wstrb  = 4'b0000;
    dmem_wdata  = store_data(w_op, ex_st_data);
    mem_rw_data = ex_alu_res;
    mem_rw_en   = ex_rw_en;
    mem_ale     = 1'b0;
    mem_stall   = 1'b0;
    if (!rst) begin
      w_next    = S_IDLE;
      mem_rw_en = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mem && w_aligned) begin
            dmem_req   = 1'b1;
            dmem_we    = is_store(w_op);
            dmem_wstrb = store_strb(w_op, w_off);
            mem_stall  = 1'b1;
            mem_rw_en  = 1'b0;
            w_next     = dmem_ack ? S_DONE : S_WAIT;
          end else if (w_is_mem) begin
            mem_ale   = 1'b1;
            mem_rw_en = 1'b0;
          end
        end
        S_WAIT: begin
          dmem_req   = 1'b1;
          dmem_we    = r_we;
          dmem_addr  = r_req_addr;
          dmem_wstrb = r_wstrb;
          dmem_wdata = r_wdata;
          mem_stall  = 1'b1;
          mem_rw_en  = 1'b0;
          w_next     = dmem_ack ? S_DONE : S_WAIT;
        end
        S_DONE: begin
          if (is_load(r_req_op)) mem_rw_data = r_result;
          else                   mem_rw_en   = 1'b0;
          w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues instructions and pushes the
// expected retire/bus results, an independent monitor pops and compares them.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ex_pc = '0, ex_inst = '0, ex_alu_res = '0, ex_st_data = '0;
  logic [3:0]  ex_mem_op = '0;
  logic [4:0]  ex_rw_addr = '0;
  logic        ex_rw_en = 1'b0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] mem_pc, mem_inst, mem_rw_data;
  logic [4:0]  mem_rw_addr;
  logic        mem_rw_en, mem_ale, mem_stall;

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_alu_res(ex_alu_res), .ex_st_data(ex_st_data),
    .ex_mem_op(ex_mem_op), .ex_rw_addr(ex_rw_addr), .ex_rw_en(ex_rw_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_rw_data(mem_rw_data),
    .mem_rw_addr(mem_rw_addr), .mem_rw_en(mem_rw_en), .mem_ale(mem_ale), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, inst, rw_data;
    logic [4:0]  rw_addr;
    logic        rw_en, ale;
    int          stalls;
  } exp_t;

  typedef struct {
    logic [31:0] addr, wdata;
    logic        we;
    logic [3:0]  strb;
  } bus_t;

  exp_t sb_q[$];
  bus_t bus_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_cnt = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int op_size(logic [3:0] op);
    if (op == LD_B || op == LD_BU || op == ST_B) return 1;
    if (op == LD_H || op == LD_HU || op == ST_H) return 2;
    return 4;
  endfunction

  // Reference load result: shift the addressed lane down, mask to size, extend.
  function automatic logic [31:0] load_model(logic [3:0] op, int size, int off, logic [31:0] rdata);
    logic [31:0] v, mask;
    v    = rdata >> (8 * off);
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    v    = v & mask;
    if ((op == LD_B || op == LD_H) && v[8*size-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic issue(input logic [31:0] pc, input logic [3:0] op, input logic [31:0] alu,
                       input logic [31:0] st, input logic [4:0] rd, input logic en,
                       input int lat, input logic [31:0] rdata, input logic fack);
    exp_t e;
    bus_t b;
    logic is_ld, is_st, mem_ok;
    int   size, off;
    is_ld  = (op >= 4'd1) && (op <= 4'd5);
    is_st  = (op >= 4'd6) && (op <= 4'd8);
    size   = op_size(op);
    off    = int'(alu % 4);
    mem_ok = (is_ld || is_st) && ((alu % size) == 0);
    e.pc = pc; e.inst = $urandom; e.rw_data = alu; e.rw_addr = rd;
    e.rw_en = en; e.ale = 1'b0; e.stalls = 0;
    if ((is_ld || is_st) && !mem_ok) begin
      e.ale = 1'b1; e.rw_en = 1'b0;
    end else if (mem_ok) begin
      e.stalls = lat + 1;
      if (is_st) e.rw_en = 1'b0;
      else       e.rw_data = load_model(op, size, off, rdata);
      b.addr  = alu & 32'hFFFF_FFFC;
      b.we    = is_st;
      b.strb  = is_st ? 4'(((1 << size) - 1) << off) : 4'b0000;
      b.wdata = (size == 1) ? {24'h0, st[7:0]} * 32'h0101_0101 :
                (size == 2) ? {16'h0, st[15:0]} * 32'h0001_0001 : st;
      bus_q.push_back(b);
    end
    sb_q.push_back(e);
    ex_pc = pc; ex_inst = e.inst; ex_alu_res = alu; ex_st_data = st;
    ex_mem_op = op; ex_rw_addr = rd; ex_rw_en = en; dmem_rdata = rdata;
    dmem_ack = (mem_ok && lat == 0) || fack;
    if (mem_ok) begin
      for (int k = 1; k <= lat + 1; k++) begin
        @(posedge clk); #1;
        dmem_ack = (k == lat);
      end
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
  endtask

  // Monitor: bus requests checked every cycle they are up; each non-stalled cycle retires one instruction.
  always @(negedge clk) begin
    if (!rst) begin
      stall_cnt = 0;
    end else if (mon_en) begin
      if (dmem_req) begin
        if (bus_q.size() == 0) begin
          check("bus_unexpected_req", 32'(dmem_req), 32'd0);
        end else begin
          check("bus_addr", dmem_addr, bus_q[0].addr);
          check("bus_we", 32'(dmem_we), 32'(bus_q[0].we));
          check("bus_wstrb", 32'(dmem_wstrb), 32'(bus_q[0].strb));
          if (bus_q[0].we) check("bus_wdata", dmem_wdata, bus_q[0].wdata);
          if (dmem_ack) void'(bus_q.pop_front());
        end
      end
      if (mem_stall) begin
        stall_cnt++;
      end else begin
        check("req_at_retire", 32'(dmem_req), 32'd0);
        if (sb_q.size() == 0) begin
          check("retire_unexpected", 32'(sb_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("pc", mem_pc, e.pc);
          check("inst", mem_inst, e.inst);
          check("rw_data", mem_rw_data, e.rw_data);
          check("rw_addr", 32'(mem_rw_addr), 32'(e.rw_addr));
          check("rw_en", 32'(mem_rw_en), 32'(e.rw_en));
          check("ale", 32'(mem_ale), 32'(e.ale));
          check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
        end
        stall_cnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // In reset with an aligned load and ack presented: nothing may leave the stage.
    ex_mem_op = LD_W; ex_alu_res = 32'h300; ex_rw_en = 1'b1; dmem_ack = 1'b1;
    #3;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_rw_en", 32'(mem_rw_en), 32'd0);
    check("rst_rw_data_pass", mem_rw_data, 32'h300);
    ex_alu_res = 32'h301;
    #1;
    check("rst_ale", 32'(mem_ale), 32'd0);
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;

    issue(32'h1000, NONE,  32'h1234, 32'h0,    5'd5, 1'b1, 0, 32'h0,        1'b0);
    issue(32'h1004, LD_B,  32'h103,  32'h0,    5'd7, 1'b1, 3, 32'h80FF_FF00, 1'b0);
    issue(32'h1008, LD_BU, 32'h103,  32'h0,    5'd8, 1'b1, 3, 32'h80FF_FF00, 1'b0);
    issue(32'h100C, ST_H,  32'h202,  32'hABCD, 5'd9, 1'b1, 1, 32'h0,        1'b0);
    issue(32'h1010, LD_W,  32'h101,  32'h0,    5'd3, 1'b1, 0, 32'h0,        1'b0);
    issue(32'h1014, LD_W,  32'h300,  32'h0,    5'd4, 1'b1, 0, 32'hDEAD_BEEF, 1'b0);
    issue(32'h1018, LD_H,  32'h102,  32'h0,    5'd6, 1'b1, 2, 32'h8001_7FFF, 1'b0);
    issue(32'h101C, ST_B,  32'h3,    32'h5A,   5'd2, 1'b1, 0, 32'h0,        1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom_range(0, 4095);
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      issue(32'h2000 + 32'(4 * i), 4'($urandom_range(0, 8)), a, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom, 1'b0);
    end

    // Reset while a load is outstanding, then a stray ack afterwards.
    ex_pc = 32'h3000; ex_mem_op = LD_W; ex_alu_res = 32'h400; ex_rw_en = 1'b1; dmem_ack = 1'b0;
    bus_q.push_back('{addr: 32'h400, wdata: 32'h0, we: 1'b0, strb: 4'b0000});
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    check("wait_rst_req", 32'(dmem_req), 32'd0);
    check("wait_rst_stall", 32'(mem_stall), 32'd0);
    check("wait_rst_rw_en", 32'(mem_rw_en), 32'd0);
    check("wait_rst_rw_data_pass", mem_rw_data, 32'h400);
    bus_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    issue(32'h3004, NONE, 32'h77,  32'h0, 5'd1, 1'b1, 0, 32'hFFFF_FFFF, 1'b1);
    issue(32'h3008, LD_W, 32'h400, 32'h0, 5'd2, 1'b1, 2, 32'h1357_9BDF, 1'b0);
    mon_en = 1'b0;

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("bus_drained", 32'(bus_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ADDR_W, 32, address width.
REQ-002 Parameter DATA_W, 32, data width; only 32 supported.
REQ-003 The clock and reset SHALL be one clock and an asynchronous active-low reset: clk, rst.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous reset, active low.
REQ-006 ex_pc  in  ADDR_W  instruction PC from EX/MEM.
REQ-007 ex_inst  in  32  instruction word.
REQ-008 ex_alu_res  in  DATA_W  effective address for mem ops, else write-back value.
REQ-009 ex_st_data  in  DATA_W  store source register.
REQ-010 ex_mem_op  in  4  mem_op_t: NONE, LD_B, LD_H, LD_W, LD_BU, LD_HU, ST_B, ST_H, ST_W.
REQ-011 ex_rw_addr  in  5  destination register; ex_rw_en  in  1  destination write enable.
REQ-012 dmem_req  out  1  bus request; dmem_we  out  1  store.
REQ-013 dmem_addr  out  ADDR_W  word-aligned address (low 2 bits zero).
REQ-014 dmem_wstrb  out  4  byte strobes; dmem_wdata  out  DATA_W  lane-replicated store data.
REQ-015 dmem_ack  in  1  request completed; dmem_rdata  in  DATA_W  load word, valid with ack.
REQ-016 mem_pc, mem_inst, mem_rw_data, mem_rw_addr, mem_rw_en  out  same widths as EX inputs  fields to MEM_WB.
REQ-017 mem_ale  out  1  address-alignment exception; mem_stall  out  1  freeze EX/MEM and upstream.

Function
REQ-018 States SHALL be IDLE, WAIT, DONE; encoding in shared package.
REQ-019 IDLE, mem_op NONE: outputs SHALL pass EX inputs combinationally (rw_data=alu_res), stall=0, no req.
REQ-020 IDLE, aligned mem op: dmem_req=1 same cycle, stall=1, mem_rw_en=0 (bubble); ack same cycle -> DONE, else -> WAIT.
REQ-021 Alignment: H ops need addr[0]=0, W ops addr[1:0]=0; violation -> no req, ale=1, rw_en=0, stall=0, stay IDLE.
REQ-022 WAIT: req, we, addr, wstrb, wdata SHALL be held stable; stall=1, rw_en=0; on ack -> DONE.
REQ-023 On ack, load data SHALL be byte/half-selected by addr[1:0] and sign- or zero-extended into a result register.
REQ-024 DONE: no req, stall=0; outputs from EX inputs except rw_data=result register (loads); rw_en = ex_rw_en for loads, 0 for stores; -> IDLE.
REQ-025 Store strobes: ST_B 0001<<addr[1:0], ST_H 0011<<addr[1:0], ST_W 1111; wdata byte/half replicated to all lanes.
REQ-026 EX inputs SHALL be stable while stall=1 (upstream contract; not checked here).
REQ-027 dmem_ack outside IDLE/WAIT SHALL be ignored; at most one request outstanding.

Reset
REQ-028 rst low SHALL immediately force IDLE, dmem_req=0, result register 0, stall=0 regardless of clk.
REQ-029 Reset during WAIT SHALL abandon the request; a late ack after reset release SHALL be ignored if in IDLE with no req.
REQ-030 In reset, pass-through outputs follow inputs; mem_rw_en and mem_ale SHALL be 0.

Structure
REQ-031 mem_op_t, state enum, and RST_VALID-style constants SHALL live in the shared constant package.
REQ-032 Load lane select/extension SHALL be a combinational sub-module load_align; all else in mem_stage.

Verification
REQ-033 ADD pass-through: alu_res=0x1234, rw_en=1, rw_addr=5 -> same cycle rw_data=0x1234, rw_en=1, stall=0, req=0.
REQ-034 LD_B addr 0x103, rdata 0x80FF_FF00, ack after 3 cycles -> stall 4 cycles, DONE rw_data=0xFFFF_FF80; LD_BU -> 0x0000_0080.
REQ-035 ST_H addr 0x202, data 0xABCD -> addr=0x200, wstrb=1100, wdata=0xABCD_ABCD, rw_en=0 in DONE.
REQ-036 LD_W addr 0x101 -> ale=1, req=0, stall=0, rw_en=0 same cycle.
REQ-037 Same-cycle ack on LD_W 0x300 -> IDLE->DONE, stall exactly 1 cycle.
REQ-038 rst low in WAIT -> req=0 immediately; ack after release ignored; next op completes normally.
